// File: rtl/ll_fifo_scheduler.sv
// Round-robin push/pop sequencer for a shared linked-list FIFO with a 1-entry registered dequeue stage.
// Optional per-queue quota enabled by defining LL_SCHED_QUOTA_EN.
module ll_fifo_scheduler #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int NUM_FIFOS = 2,
  parameter int QUOTA     = 3,
  parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FIFOS-1:0]           req_push,
  input  logic [NUM_FIFOS*WIDTH-1:0]     req_data,
  output logic [NUM_FIFOS-1:0]           req_grant,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [WIDTH-1:0]               deq_data,
  output logic [SEL_WIDTH-1:0]           deq_sel,
  output logic                           ll_push,
  output logic                           ll_pop,
  output logic [SEL_WIDTH-1:0]           ll_push_sel,
  output logic [SEL_WIDTH-1:0]           ll_pop_sel,
  output logic [WIDTH-1:0]               ll_data_in,
  input  logic                           ll_full,
  input  logic [NUM_FIFOS-1:0]           ll_empty,
  input  logic [WIDTH-1:0]               ll_data_out,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] occ
);

  logic [SEL_WIDTH-1:0] push_ptr_q, push_ptr_d;
  logic [SEL_WIDTH-1:0] pop_ptr_q, pop_ptr_d;
  logic                 deq_valid_q, deq_valid_d;
  logic [WIDTH-1:0]     deq_data_q, deq_data_d;
  logic [SEL_WIDTH-1:0] deq_sel_q, deq_sel_d;
  logic [CNT_WIDTH-1:0] occ_q [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] occ_d [NUM_FIFOS];

  logic [NUM_FIFOS-1:0] push_elig;
  logic [SEL_WIDTH:0]   push_pick, pop_pick;
  logic                 can_load;
  logic                 do_push, do_pop;
  logic [SEL_WIDTH-1:0] push_idx, pop_idx;
  int                   occ_sum;

  // Returns {found, index}: first set bit of elig at or after ptr, wrapping.
  function automatic logic [SEL_WIDTH:0] rr_pick(input logic [NUM_FIFOS-1:0] elig,
                                                  input logic [SEL_WIDTH-1:0] ptr);
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr) + k) % NUM_FIFOS;
      if (elig[c]) begin
        found = 1'b1;
        idx   = SEL_WIDTH'(c);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [SEL_WIDTH-1:0] rr_next(input logic [SEL_WIDTH-1:0] idx);
    return SEL_WIDTH'((int'(idx) + 1) % NUM_FIFOS);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_elig[i] = req_push[i] & ~ll_full;
`ifdef LL_SCHED_QUOTA_EN
      push_elig[i] = push_elig[i] & (occ_q[i] < CNT_WIDTH'(QUOTA));
`endif
    end
  end

  assign push_pick = rr_pick(push_elig, push_ptr_q);
  assign pop_pick  = rr_pick(~ll_empty, pop_ptr_q);
  assign can_load  = ~deq_valid_q | deq_ready;
  assign do_push   = ~rst & push_pick[SEL_WIDTH];
  assign do_pop    = ~rst & can_load & pop_pick[SEL_WIDTH];
  assign push_idx  = push_pick[SEL_WIDTH-1:0];
  assign pop_idx   = pop_pick[SEL_WIDTH-1:0];

  always_comb begin
    req_grant   = '0;
    ll_push     = 1'b0;
    ll_push_sel = '0;
    ll_data_in  = '0;
    ll_pop      = 1'b0;
    ll_pop_sel  = '0;
    if (do_push) begin
      req_grant[push_idx] = 1'b1;
      ll_push             = 1'b1;
      ll_push_sel         = push_idx;
      ll_data_in          = req_data[push_idx*WIDTH +: WIDTH];
    end
    if (do_pop) begin
      ll_pop     = 1'b1;
      ll_pop_sel = pop_idx;
    end
  end

  always_comb begin
    push_ptr_d  = do_push ? rr_next(push_idx) : push_ptr_q;
    pop_ptr_d   = pop_ptr_q;
    deq_valid_d = deq_valid_q;
    deq_data_d  = deq_data_q;
    deq_sel_d   = deq_sel_q;
    if (do_pop) begin
      pop_ptr_d   = rr_next(pop_idx);
      deq_valid_d = 1'b1;
      deq_data_d  = ll_data_out;
      deq_sel_d   = pop_idx;
    end else if (can_load && deq_ready) begin
      deq_valid_d = 1'b0;
    end
  end

  // A push and a pop on the same queue cancel out.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      occ_d[i] = occ_q[i];
      if (do_push && (push_idx == SEL_WIDTH'(i))) occ_d[i] = occ_d[i] + CNT_WIDTH'(1);
      if (do_pop && (pop_idx == SEL_WIDTH'(i)))   occ_d[i] = occ_d[i] - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_ptr_q  <= '0;
      pop_ptr_q   <= '0;
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
      deq_sel_q   <= '0;
      for (int i = 0; i < NUM_FIFOS; i++) occ_q[i] <= '0;
    end else begin
      push_ptr_q  <= push_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
      deq_sel_q   <= deq_sel_d;
      for (int i = 0; i < NUM_FIFOS; i++) occ_q[i] <= occ_d[i];
    end
  end

  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign deq_sel   = deq_sel_q;

  always_comb begin
    occ     = '0;
    occ_sum = 0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      occ[i*CNT_WIDTH +: CNT_WIDTH] = occ_q[i];
      occ_sum = occ_sum + int'(occ_q[i]);
    end
  end

  // Counters must mirror the FIFO's own per-queue state exactly.
  always @(posedge clk) begin
    if (!rst) begin
      assert (QUOTA >= 1 && QUOTA <= DEPTH);
      assert (!(ll_pop && ll_empty[ll_pop_sel]));
      assert (!(ll_push && ll_full));
      assert (occ_sum <= DEPTH);
      assert (!(ll_full && occ_sum != DEPTH));
      for (int i = 0; i < NUM_FIFOS; i++) begin
        assert (ll_empty[i] == (occ_q[i] == '0));
        assert (!(do_pop && pop_idx == SEL_WIDTH'(i) && occ_q[i] == '0));
      end
    end
  end

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Bench for ll_fifo_scheduler: behavioural shared-FIFO environment plus rule-level scheduler model.
module tb_ll_fifo_scheduler;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int NUM_FIFOS = 2;
  localparam int QUOTA     = 3;
  localparam int SEL_WIDTH = 1;
  localparam int CNT_WIDTH = 3;
  localparam int DW        = NUM_FIFOS * WIDTH;

  logic                           clk = 1'b0;
  logic                           rst;
  logic [NUM_FIFOS-1:0]           req_push;
  logic [DW-1:0]                  req_data;
  logic [NUM_FIFOS-1:0]           req_grant;
  logic                           deq_valid;
  logic                           deq_ready;
  logic [WIDTH-1:0]               deq_data;
  logic [SEL_WIDTH-1:0]           deq_sel;
  logic                           ll_push, ll_pop;
  logic [SEL_WIDTH-1:0]           ll_push_sel, ll_pop_sel;
  logic [WIDTH-1:0]               ll_data_in;
  logic                           ll_full;
  logic [NUM_FIFOS-1:0]           ll_empty;
  logic [WIDTH-1:0]               ll_data_out;
  logic [NUM_FIFOS*CNT_WIDTH-1:0] occ;

  ll_fifo_scheduler #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NUM_FIFOS), .QUOTA(QUOTA),
    .SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .req_push(req_push), .req_data(req_data), .req_grant(req_grant),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data), .deq_sel(deq_sel),
    .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
    .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty), .ll_data_out(ll_data_out),
    .occ(occ)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Shared FIFO contents, one circular buffer per logical queue.
  logic [WIDTH-1:0] mem [NUM_FIFOS][DEPTH];
  int               hd  [NUM_FIFOS];
  int               cnt [NUM_FIFOS];

  // Scheduler model state.
  int               m_push_ptr, m_pop_ptr, m_ds;
  logic             m_dv;
  logic [WIDTH-1:0] m_dd;

  function automatic int total();
    int s = 0;
    for (int i = 0; i < NUM_FIFOS; i++) s += cnt[i];
    return s;
  endfunction

  function automatic bit eligible(input int q, input logic [NUM_FIFOS-1:0] rp);
    bit e;
    e = rp[q] && (total() < DEPTH);
`ifdef LL_SCHED_QUOTA_EN
    e = e && (cnt[q] < QUOTA);
`endif
    return e;
  endfunction

  task automatic env_drive();
    ll_full = (total() >= DEPTH);
    for (int i = 0; i < NUM_FIFOS; i++) ll_empty[i] = (cnt[i] == 0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NUM_FIFOS; i++) begin
      hd[i]  = 0;
      cnt[i] = 0;
    end
    m_push_ptr = 0;
    m_pop_ptr  = 0;
    m_ds       = 0;
    m_dv       = 1'b0;
    m_dd       = '0;
    ll_data_out = '0;
    env_drive();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs applied just after negedge, combinational outputs checked before
  // the posedge, registered outputs checked at the following negedge.
  task automatic step(input logic [NUM_FIFOS-1:0] rp, input logic [DW-1:0] rd, input logic dr);
    int gi, pj, q, gsel;
    bit can_load, ok_push;
    logic s_push, s_pop;
    logic [SEL_WIDTH-1:0] s_psel, s_osel;
    logic [WIDTH-1:0] s_din;
    req_push  = rp;
    req_data  = rd;
    deq_ready = dr;
    #1;
    ll_data_out = (cnt[ll_pop_sel] > 0) ? mem[ll_pop_sel][hd[ll_pop_sel]] : '0;
    #1;
    gi = -1;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      q = (m_push_ptr + k) % NUM_FIFOS;
      if (gi < 0 && eligible(q, rp)) gi = q;
    end
    can_load = !m_dv || dr;
    pj = -1;
    if (can_load) begin
      for (int k = 0; k < NUM_FIFOS; k++) begin
        q = (m_pop_ptr + k) % NUM_FIFOS;
        if (pj < 0 && cnt[q] > 0) pj = q;
      end
    end
    gsel = (gi >= 0) ? gi : 0;
    chk("req_grant",   32'(req_grant),   (gi >= 0) ? (32'd1 << gi) : 32'd0);
    chk("ll_push",     32'(ll_push),     (gi >= 0) ? 32'd1 : 32'd0);
    chk("ll_push_sel", 32'(ll_push_sel), 32'(gsel));
    chk("ll_data_in",  32'(ll_data_in),  (gi >= 0) ? 32'(rd[gsel*WIDTH +: WIDTH]) : 32'd0);
    chk("ll_pop",      32'(ll_pop),      (pj >= 0) ? 32'd1 : 32'd0);
    chk("ll_pop_sel",  32'(ll_pop_sel),  (pj >= 0) ? 32'(pj) : 32'd0);
    if (gi >= 0) m_push_ptr = (gi + 1) % NUM_FIFOS;
    if (pj >= 0) begin
      m_dv      = 1'b1;
      m_dd      = mem[pj][hd[pj]];
      m_ds      = pj;
      m_pop_ptr = (pj + 1) % NUM_FIFOS;
    end else if (can_load && dr) begin
      m_dv = 1'b0;
    end
    s_push = ll_push;
    s_pop  = ll_pop;
    s_psel = ll_push_sel;
    s_osel = ll_pop_sel;
    s_din  = ll_data_in;
    @(posedge clk);
    #1;
    ok_push = s_push && (total() < DEPTH);
    if (s_pop && cnt[s_osel] > 0) begin
      hd[s_osel]  = (hd[s_osel] + 1) % DEPTH;
      cnt[s_osel] = cnt[s_osel] - 1;
    end
    if (ok_push) begin
      mem[s_psel][(hd[s_psel] + cnt[s_psel]) % DEPTH] = s_din;
      cnt[s_psel] = cnt[s_psel] + 1;
    end
    env_drive();
    @(negedge clk);
    chk("deq_valid", 32'(deq_valid), 32'(m_dv));
    if (m_dv) begin
      chk("deq_data", 32'(deq_data), 32'(m_dd));
      chk("deq_sel",  32'(deq_sel),  32'(m_ds));
    end
    for (int i = 0; i < NUM_FIFOS; i++)
      chk("occ", 32'(occ[i*CNT_WIDTH +: CNT_WIDTH]), 32'(cnt[i]));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_grant",   32'(req_grant),   32'd0);
    chk("rst_ll_push",     32'(ll_push),     32'd0);
    chk("rst_ll_pop",      32'(ll_pop),      32'd0);
    chk("rst_ll_push_sel", 32'(ll_push_sel), 32'd0);
    chk("rst_ll_pop_sel",  32'(ll_pop_sel),  32'd0);
    chk("rst_ll_data_in",  32'(ll_data_in),  32'd0);
    chk("rst_deq_valid",   32'(deq_valid),   32'd0);
    chk("rst_deq_data",    32'(deq_data),    32'd0);
    chk("rst_deq_sel",     32'(deq_sel),     32'd0);
    chk("rst_occ",         32'(occ),         32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_push  = '0;
    req_data  = '0;
    deq_ready = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;

    // Push fairness under backpressure until the shared FIFO fills.
    for (int i = 0; i < 6; i++) step(2'b11, DW'($urandom), 1'b0);
    // Stalled consumer: output stage must hold.
    for (int i = 0; i < 3; i++) step(2'b00, '0, 1'b0);
    // Full FIFO with a draining consumer: no same-cycle bypass.
    for (int i = 0; i < 3; i++) step(2'b01, DW'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) step(2'b00, '0, 1'b1);
    // Interleaved queue contents drained round-robin.
    step(2'b01, 16'h00A0, 1'b0);
    step(2'b01, 16'h00A1, 1'b0);
    step(2'b10, 16'hC000, 1'b0);
    step(2'b01, 16'h00B0, 1'b0);
    step(2'b10, 16'hD000, 1'b0);
    for (int i = 0; i < 7; i++) step(2'b00, '0, 1'b1);
    // Single requester saturating the FIFO (quota-limited when enabled).
    for (int i = 0; i < 5; i++) step(2'b01, DW'($urandom), 1'b0);
    step(2'b10, DW'($urandom), 1'b0);
    step(2'b10, DW'($urandom), 1'b0);

    // Asynchronous reset in the middle of a cycle.
    req_push  = 2'b11;
    req_data  = DW'($urandom);
    deq_ready = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    clear_all();
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    // Pointers restart at zero: queue 0 wins first.
    step(2'b11, 16'h2211, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic dr;
      dr = (i % 50 < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(NUM_FIFOS'($urandom), DW'($urandom), dr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
